// File: rtl/board_snapshot_fetcher.sv
// Copies the board rows from memory port 2 into a double-buffered row store once per frame,
// so the renderer always reads a complete, stable snapshot while the CPU edits the board.
//
//   state | meaning
//   IDLE  | waiting for frame_start; mem_addr parked at BOARD_BASE
//   FETCH | reading rows into the back buffer; swap on the last capture
module board_snapshot_fetcher #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BOARD_BASE = 10'h3C0,
    parameter int                    BOARD_ROWS = 20,
    parameter int                    BOARD_COLS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [4:0]            rd_row,
    input  logic [3:0]            rd_col,
    output logic                  cell_on,
    output logic [DATA_WIDTH-1:0] row_word,
    output logic                  busy,
    output logic                  done,
    output logic                  snap_valid,
    output logic                  overrun
);

    localparam logic [4:0] LAST_IDX = 5'(BOARD_ROWS - 1);
    localparam logic [4:0] ROW_LIM  = 5'(BOARD_ROWS);
    localparam logic [3:0] COL_LIM  = 4'(BOARD_COLS);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [4:0]            cap_idx, cap_idx_nxt;
    logic                  busy_nxt, done_nxt, overrun_nxt;
    logic                  capture, swap;
    logic                  front_sel;
    logic [DATA_WIDTH-1:0] buf0 [BOARD_ROWS];
    logic [DATA_WIDTH-1:0] buf1 [BOARD_ROWS];

    always_comb begin
        state_nxt   = state;
        addr_nxt    = mem_addr;
        cap_idx_nxt = cap_idx;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        overrun_nxt = overrun;
        capture     = 1'b0;
        swap        = 1'b0;
        case (state)
            IDLE: begin
                addr_nxt = BOARD_BASE;
                busy_nxt = 1'b0;
                if (frame_start) begin
                    state_nxt   = FETCH;
                    busy_nxt    = 1'b1;
                    cap_idx_nxt = '0;
                end
            end
            FETCH: begin
                // mem_rdata here answers the address registered on the previous edge
                capture = 1'b1;
                if (frame_start) overrun_nxt = 1'b1;
                if (cap_idx == LAST_IDX) begin
                    swap        = 1'b1;
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                    busy_nxt    = 1'b0;
                    addr_nxt    = BOARD_BASE;
                    cap_idx_nxt = '0;
                end else begin
                    cap_idx_nxt = cap_idx + 5'd1;
                    addr_nxt    = BOARD_BASE + ADDR_WIDTH'(cap_idx + 5'd1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_addr   <= BOARD_BASE;
            cap_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            snap_valid <= 1'b0;
            overrun    <= 1'b0;
            front_sel  <= 1'b0;
        end else begin
            state    <= state_nxt;
            mem_addr <= addr_nxt;
            cap_idx  <= cap_idx_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            overrun  <= overrun_nxt;
            if (swap) begin
                front_sel  <= ~front_sel;
                snap_valid <= 1'b1;
            end
        end
    end

    // The back buffer is whichever one front_sel is not pointing at.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BOARD_ROWS; i++) begin
                buf0[i] <= '0;
                buf1[i] <= '0;
            end
        end else if (capture) begin
            if (front_sel) buf0[cap_idx] <= mem_rdata;
            else           buf1[cap_idx] <= mem_rdata;
        end
    end

    always_comb begin
        row_word = '0;
        if (rd_row < ROW_LIM) row_word = front_sel ? buf1[rd_row] : buf0[rd_row];
        cell_on = (rd_col < COL_LIM) ? row_word[rd_col] : 1'b0;
    end

endmodule

// File: tb/tb_board_snapshot_fetcher.sv
// Bench for board_snapshot_fetcher: behavioural memory on port 2, expected snapshots
// queued when each fetch is started and compared against the front buffer after done.
module tb_board_snapshot_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [9:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic [4:0]  rd_row;
    logic [3:0]  rd_col;
    logic        cell_on;
    logic [15:0] row_word;
    logic        busy, done, snap_valid, overrun;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic [15:0]  mem [0:1023];
    logic [319:0] exp_q [$];

    board_snapshot_fetcher dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .cell_on     (cell_on),
        .row_word    (row_word),
        .busy        (busy),
        .done        (done),
        .snap_valid  (snap_valid),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) mem_rdata <= mem[mem_addr];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    function automatic logic [319:0] snap_of_mem();
        logic [319:0] s;
        for (int i = 0; i < 20; i++) s[i*16 +: 16] = mem[10'h3C0 + i];
        return s;
    endfunction

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic compare_snapshot(input string tag);
        logic [319:0] s;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
            return;
        end
        s = exp_q.pop_front();
        for (int i = 0; i < 20; i++) begin
            rd_row = 5'(i);
            rd_col = 4'd0;
            #1;
            check($sformatf("%s_row%0d", tag, i), row_word, s[i*16 +: 16]);
            for (int c = 0; c < 16; c++) begin
                rd_col = 4'(c);
                #1;
                check($sformatf("%s_cell%0d_%0d", tag, i, c), cell_on,
                      (c < 10) ? s[i*16 + c] : 1'b0);
            end
        end
        tick();
    endtask

    task automatic do_fetch(input string tag);
        exp_q.push_back(snap_of_mem());
        pulse_frame();
        wait_done(25);
        tick();
        compare_snapshot(tag);
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < 22; r++) begin
            rd_row = 5'(r);
            rd_col = 4'd0;
            #1;
            check($sformatf("%s_row%0d", tag, r), row_word, 0);
            for (int c = 0; c < 16; c++) begin
                rd_col = 4'(c);
                #1;
                check($sformatf("%s_cell%0d_%0d", tag, r, c), cell_on, 0);
            end
        end
        tick();
    endtask

    initial begin
        logic [319:0] s;
        int base_cnt;
        reset       = 1'b1;
        frame_start = 1'b0;
        rd_row      = '0;
        rd_col      = '0;
        for (int a = 0; a < 1024; a++) mem[a] = '0;
        for (int i = 0; i < 20; i++) mem[10'h3C0 + i] = 16'h8000 | 16'(i);

        // reset state with memory already holding a board
        tick();
        tick();
        reset = 1'b0;
        check("rst_addr", mem_addr, 32'h3C0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", snap_valid, 0);
        check("rst_overrun", overrun, 0);
        check_all_zero("rst");

        // first fetch: exact address sequence and done timing
        exp_q.push_back(snap_of_mem());
        pulse_frame();
        check("f1_addr0", mem_addr, 32'h3C0);
        check("f1_busy0", busy, 1);
        for (int k = 1; k < 20; k++) begin
            tick();
            check($sformatf("f1_addr%0d", k), mem_addr, 32'h3C0 + k);
            check($sformatf("f1_done%0d", k), done, 0);
            check($sformatf("f1_busy%0d", k), busy, 1);
        end
        tick();
        check("f1_done_swap", done, 1);
        check("f1_busy_swap", busy, 0);
        check("f1_valid", snap_valid, 1);
        check("f1_addr_idle", mem_addr, 32'h3C0);
        tick();
        check("f1_done_after", done, 0);
        rd_row = 5'd5;
        rd_col = 4'd0;
        #1;
        check("f1_row5", row_word, 32'h8005);
        check("f1_cell5_0", cell_on, 1);
        rd_col = 4'd1;
        #1;
        check("f1_cell5_1", cell_on, 0);
        rd_col = 4'd2;
        #1;
        check("f1_cell5_2", cell_on, 1);
        compare_snapshot("f1");

        // second fetch with row 3 rewritten before it is read: no tearing of the front buffer
        s = snap_of_mem();
        s[3*16 +: 16] = 16'h03FF;
        exp_q.push_back(s);
        rd_row = 5'd3;
        rd_col = 4'd0;
        pulse_frame();
        check("f2_row3_k0", row_word, 32'h8003);
        for (int k = 1; k < 20; k++) begin
            tick();
            if (k == 2) mem[10'h3C3] = 16'h03FF;
            check($sformatf("f2_row3_k%0d", k), row_word, 32'h8003);
        end
        tick();
        check("f2_done", done, 1);
        check("f2_row3_swap", row_word, 32'h03FF);
        tick();
        compare_snapshot("f2");

        // frame_start during a fetch and on its completion edge
        exp_q.push_back(snap_of_mem());
        pulse_frame();
        for (int k = 1; k < 20; k++) begin
            tick();
            if (k == 6) begin
                check("ov_before", overrun, 0);
                frame_start = 1'b1;
            end
            if (k == 7) begin
                frame_start = 1'b0;
                check("ov_set", overrun, 1);
                check("ov_busy", busy, 1);
                check("ov_addr", mem_addr, 32'h3C7);
            end
            if (k == 19) frame_start = 1'b1;
        end
        tick();
        frame_start = 1'b0;
        check("ov_done", done, 1);
        check("ov_sticky", overrun, 1);
        tick();
        check("ov_idle_busy", busy, 0);
        check("ov_idle_done", done, 0);
        check("ov_idle_addr", mem_addr, 32'h3C0);
        check("ov_still", overrun, 1);
        compare_snapshot("ov");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ov_cleared", overrun, 0);
        check("ov_rst_valid", snap_valid, 0);
        rd_row = 5'd3;
        #1;
        check("ov_rst_row3", row_word, 0);
        tick();

        // out-of-range lookups
        mem[10'h3C0] = 16'hFFFF;
        do_fetch("oor");
        rd_row = 5'd20;
        rd_col = 4'd0;
        #1;
        check("oor_row20_word", row_word, 0);
        check("oor_row20_cell", cell_on, 0);
        rd_row = 5'd31;
        #1;
        check("oor_row31_word", row_word, 0);
        rd_row = 5'd0;
        rd_col = 4'd12;
        #1;
        check("oor_col12_cell", cell_on, 0);
        check("oor_col12_word", row_word, 32'hFFFF);
        rd_col = 4'd9;
        #1;
        check("oor_col9_cell", cell_on, 1);
        rd_col = 4'd10;
        #1;
        check("oor_col10_cell", cell_on, 0);
        tick();

        // reset in the middle of a fetch abandons it
        base_cnt = done_cnt;
        pulse_frame();
        for (int k = 1; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_addr", mem_addr, 32'h3C0);
        check("mr_valid", snap_valid, 0);
        for (int k = 0; k < 25; k++) tick();
        check("mr_no_done", done_cnt, base_cnt);
        check("mr_addr_idle", mem_addr, 32'h3C0);
        check_all_zero("mr");
        do_fetch("mr_refetch");
        check("mr_refetch_valid", snap_valid, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
